// File: rtl/irq_control_unit.sv
// Multicycle MIPS-style control FSM with a single-level interrupt/NMI entry path.
// Vectors are registered on entry; ERET leaves the handler and reopens interrupt sampling.
module irq_control_unit #(
    parameter int          NUM_IRQ     = 4,
    parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE  = 32'd16,
    parameter logic [5:0]  ERET_OPCODE = 6'b010000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               nmint,
    input  logic               busy,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               IorD,
    output logic               ALUSrcA,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               PCWrite,
    output logic               Branch,
    output logic               RegWrite,
    output logic [2:0]         PCSrc,
    output logic               savePC,
    output logic [31:0]        vector_addr,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               nmi_ack,
    output logic               in_service,
    output logic [3:0]         current_state
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_IRQENTRY = 4'd12,
        S_ERET     = 4'd13
    } state_t;

    state_t             state;
    logic               taken_nmi;
    logic [NUM_IRQ-1:0] taken_irq;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_sel;
    logic [4:0]         irq_idx;
    logic [31:0]        irq_vec;
    logic               take_nmi;
    logic               take_irq;
    logic               take;

    assign pending = irq & ~irq_mask;

    // Lowest-index pending channel wins: scan from the top so the last hit is the lowest.
    always_comb begin
        irq_idx = '0;
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                irq_idx    = 5'(i);
                irq_sel    = '0;
                irq_sel[i] = 1'b1;
            end
        end
    end

    assign irq_vec  = VEC_BASE + (32'(irq_idx) + 32'd1) * VEC_STRIDE;
    assign take_nmi = nmint;
    assign take_irq = ~nmint & ~busy & (|pending);
    assign take     = (state == S_FETCH) & ~in_service & (take_nmi | take_irq);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FETCH;
            in_service  <= 1'b0;
            vector_addr <= '0;
            taken_nmi   <= 1'b0;
            taken_irq   <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (take) begin
                        state       <= S_IRQENTRY;
                        in_service  <= 1'b1;
                        taken_nmi   <= take_nmi;
                        taken_irq   <= take_nmi ? '0 : irq_sel;
                        vector_addr <= take_nmi ? VEC_BASE : irq_vec;
                    end else begin
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
                        ERET_OPCODE:  state <= S_ERET;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD: state <= S_MEMWB;
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                S_ERET: begin
                    in_service <= 1'b0;
                    state      <= S_FETCH;
                end
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        ALUOp    = 2'd0;
        ALUSrcB  = 2'd0;
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        RegWrite = 1'b0;
        PCSrc    = 3'd0;
        savePC   = 1'b0;
        case (state)
            S_FETCH: begin
                // An interrupt steals the fetch slot: the PC and IR must stay untouched.
                IRWrite = ~take;
                PCWrite = ~take;
                ALUSrcB = 2'd1;
            end
            S_DECODE:   ALUSrcB = 2'd3;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd2;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'd1;
                PCSrc   = 3'd1;
                Branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 3'd2;
                PCWrite = 1'b1;
            end
            S_IRQENTRY: begin
                savePC  = 1'b1;
                PCSrc   = 3'd3;
                PCWrite = 1'b1;
            end
            S_ERET: begin
                PCSrc   = in_service ? 3'd4 : 3'd0;
                PCWrite = in_service;
            end
            default: ;
        endcase
    end

    assign irq_ack       = (state == S_IRQENTRY) ? taken_irq : '0;
    assign nmi_ack       = (state == S_IRQENTRY) & taken_nmi;
    assign current_state = state;

endmodule

// File: tb/tb_irq_control_unit.sv
// Bench for irq_control_unit: instruction-level sequence model plus directed literal checks,
// followed by a randomized run compared against the model every cycle.
module tb_irq_control_unit;

    localparam int          N  = 4;
    localparam logic [31:0] VB = 32'h0000_0100;
    localparam logic [31:0] VS = 32'd16;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ERET = 6'b010000;

    logic clk = 1'b0;
    logic rst, nmint, busy;
    logic [5:0] opcode;
    logic [N-1:0] irq, irq_mask;
    logic [1:0] ALUOp, ALUSrcB;
    logic MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite;
    logic [2:0] PCSrc;
    logic savePC, nmi_ack, in_service;
    logic [31:0] vector_addr;
    logic [N-1:0] irq_ack;
    logic [3:0] current_state;

    always #5 clk = ~clk;

    irq_control_unit #(.NUM_IRQ(N), .VEC_BASE(VB), .VEC_STRIDE(VS), .ERET_OPCODE(OP_ERET)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .irq(irq), .irq_mask(irq_mask),
        .nmint(nmint), .busy(busy), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite), .PCSrc(PCSrc), .savePC(savePC),
        .vector_addr(vector_addr), .irq_ack(irq_ack), .nmi_ack(nmi_ack), .in_service(in_service),
        .current_state(current_state)
    );

    typedef struct packed {
        logic [1:0] aluop, alusrcb;
        logic memtoreg, regdst, iord, alusrca, irwrite, memwrite, pcwrite, branch, regwrite;
        logic [2:0] pcsrc;
        logic savepc;
    } ctl_t;

    ctl_t dut_ctl;
    ctl_t tab [0:13];
    assign dut_ctl = {ALUOp, ALUSrcB, MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite,
                      PCWrite, Branch, RegWrite, PCSrc, savePC};

    // Model: current state, remaining states of the instruction in flight, handler status.
    int          m_state;
    int          pend[$];
    bit          m_svc, m_nmi;
    logic [31:0] m_vec;
    logic [N-1:0] m_irq1h;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_take();
        return (m_state == 0) && !m_svc && (nmint || (!busy && |(irq & ~irq_mask)));
    endfunction

    task automatic advance();
        if (rst) begin
            m_state = 0; m_svc = 0; m_vec = '0; m_nmi = 0; m_irq1h = '0;
            pend.delete();
            return;
        end
        if (m_state == 0) begin
            if (m_take()) begin
                m_svc = 1; m_nmi = nmint; m_irq1h = '0;
                if (nmint) m_vec = VB;
                else begin
                    for (int k = 0; k < N; k++) begin
                        if (irq[k] && !irq_mask[k]) begin
                            m_irq1h[k] = 1'b1;
                            m_vec = 32'(VB + 32'(k + 1) * VS);
                            break;
                        end
                    end
                end
                m_state = 12;
                return;
            end
            case (opcode)
                OP_LW:   pend = '{1, 2, 3, 4};
                OP_SW:   pend = '{1, 2, 5};
                OP_R:    pend = '{1, 6, 7};
                OP_ADDI: pend = '{1, 9, 10};
                OP_BEQ:  pend = '{1, 8};
                OP_J:    pend = '{1, 11};
                OP_ERET: pend = '{1, 13};
                default: pend = '{1};
            endcase
        end else if (m_state == 13) begin
            m_svc = 0;
        end
        m_state = (pend.size() > 0) ? pend.pop_front() : 0;
    endtask

    task automatic compare();
        ctl_t e;
        logic [N-1:0] eack;
        e = tab[m_state];
        if (m_state == 0 && m_take()) begin e.irwrite = 0; e.pcwrite = 0; end
        if (m_state == 13 && m_svc) begin e.pcsrc = 3'd4; e.pcwrite = 1; end
        eack = (m_state == 12 && !m_nmi) ? m_irq1h : '0;
        chk("state", 32'(current_state), 32'(m_state));
        chk("ctl", 32'(dut_ctl), 32'(e));
        chk("in_service", 32'(in_service), 32'(m_svc));
        chk("vector_addr", vector_addr, m_vec);
        chk("irq_ack", 32'(irq_ack), 32'(eack));
        chk("nmi_ack", 32'(nmi_ack), 32'(m_state == 12 && m_nmi));
    endtask

    task automatic step();
        @(posedge clk);
        advance();
        @(negedge clk);
        compare();
    endtask

    // Runs one instruction from FETCH; trace holds the visited states after FETCH as hex nibbles.
    task automatic run_instr(input logic [5:0] op, input logic [31:0] exp_trace, input string name);
        logic [31:0] tr;
        bit rw_bad;
        int n;
        opcode = op; tr = '0; rw_bad = 0; n = 0;
        do begin
            step();
            n++;
            if (current_state != 4'd0) begin
                tr = (tr << 4) | 32'(current_state);
                if (RegWrite && !(current_state inside {4'd4, 4'd7, 4'd10})) rw_bad = 1;
            end
        end while (current_state != 4'd0 && n < 8);
        chk({name, "_trace"}, tr, exp_trace);
        chk({name, "_regwrite"}, 32'(rw_bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        foreach (tab[i]) tab[i] = '0;
        tab[0].irwrite = 1; tab[0].pcwrite = 1; tab[0].alusrcb = 2'd1;
        tab[1].alusrcb = 2'd3;
        tab[2].alusrca = 1; tab[2].alusrcb = 2'd2;
        tab[3].iord = 1;
        tab[4].memtoreg = 1; tab[4].regwrite = 1;
        tab[5].iord = 1; tab[5].memwrite = 1;
        tab[6].alusrca = 1; tab[6].aluop = 2'd2;
        tab[7].regdst = 1; tab[7].regwrite = 1;
        tab[8].alusrca = 1; tab[8].aluop = 2'd1; tab[8].pcsrc = 3'd1; tab[8].branch = 1;
        tab[9].alusrca = 1; tab[9].alusrcb = 2'd2;
        tab[10].regwrite = 1;
        tab[11].pcsrc = 3'd2; tab[11].pcwrite = 1;
        tab[12].savepc = 1; tab[12].pcsrc = 3'd3; tab[12].pcwrite = 1;

        m_state = 0; m_svc = 0; m_nmi = 0; m_vec = '0; m_irq1h = '0;
        rst = 1; irq = '0; irq_mask = '0; nmint = 0; busy = 0; opcode = OP_J;
        @(negedge clk);
        step(); step();
        chk("rst_state", 32'(current_state), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_vector", vector_addr, 32'd0);
        chk("rst_acks", 32'({irq_ack, nmi_ack}), 32'd0);
        rst = 0;

        // Plain instruction sequence
        run_instr(OP_LW,   32'h1234, "lw");
        run_instr(OP_SW,   32'h125,  "sw");
        run_instr(OP_R,    32'h167,  "rtype");
        run_instr(OP_ADDI, 32'h19A,  "addi");
        run_instr(OP_BEQ,  32'h18,   "beq");
        run_instr(OP_J,    32'h1B,   "j");
        run_instr(6'b111111, 32'h1,  "unknown");

        // ERET outside a handler does nothing
        opcode = OP_ERET;
        step(); step();
        chk("eret_idle_state", 32'(current_state), 32'd13);
        chk("eret_idle_pcwrite", 32'(PCWrite), 32'd0);
        step();

        // Maskable entry, lowest pending channel
        irq = 4'b0110;
        step();
        chk("irq_state", 32'(current_state), 32'd12);
        chk("irq_vector", vector_addr, 32'h120);
        chk("irq_ack", 32'(irq_ack), 32'h2);
        chk("irq_savepc", 32'(savePC), 32'd1);
        chk("irq_pcsrc", 32'(PCSrc), 32'd3);
        irq = '0;
        step();
        chk("irq_ack_once", 32'(irq_ack), 32'd0);
        chk("irq_in_service", 32'(in_service), 32'd1);
        opcode = OP_ERET;
        step(); step();
        chk("eret_pcsrc", 32'(PCSrc), 32'd4);
        chk("eret_pcwrite", 32'(PCWrite), 32'd1);
        step();
        chk("eret_in_service", 32'(in_service), 32'd0);

        // NMI beats busy-deferred IRQ; IRQ held until after ERET
        nmint = 1; irq = 4'b0001; busy = 1;
        step();
        chk("nmi_vector", vector_addr, 32'h100);
        chk("nmi_ack", 32'(nmi_ack), 32'd1);
        chk("nmi_irq_ack", 32'(irq_ack), 32'd0);
        nmint = 0; busy = 0;
        step();
        run_instr(OP_R, 32'h167, "nonest");
        run_instr(OP_ERET, 32'h1D, "eret_nmi");
        step();
        chk("post_eret_state", 32'(current_state), 32'd12);
        chk("post_eret_vector", vector_addr, 32'h110);
        chk("post_eret_ack", 32'(irq_ack), 32'h1);
        irq = '0;
        step();
        run_instr(OP_ERET, 32'h1D, "eret_irq0");

        // Deferred or masked requests leave normal fetch alone
        busy = 1; irq = 4'hF;
        run_instr(OP_ADDI, 32'h19A, "busy_addi");
        busy = 0; irq_mask = 4'hF;
        run_instr(OP_J, 32'h1B, "mask_j");
        irq = '0; irq_mask = '0;

        // Reset mid-instruction and mid-entry
        opcode = OP_LW;
        step(); step(); step();
        chk("pre_rst_memread", 32'(current_state), 32'd3);
        rst = 1;
        step();
        chk("rst_mid_state", 32'(current_state), 32'd0);
        rst = 0;
        irq = 4'b0100;
        step();
        chk("pre_rst_entry", 32'(current_state), 32'd12);
        rst = 1;
        step();
        chk("rst_entry_state", 32'(current_state), 32'd0);
        chk("rst_entry_acks", 32'({irq_ack, nmi_ack}), 32'd0);
        chk("rst_entry_svc", 32'(in_service), 32'd0);
        chk("rst_entry_vec", vector_addr, 32'd0);
        rst = 0; irq = '0;

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 99) == 0);
            irq      = N'($urandom);
            irq_mask = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
            busy     = ($urandom_range(0, 3) == 0);
            nmint    = ($urandom_range(0, 19) == 0);
            if (m_state == 0) begin
                case ($urandom_range(0, 8))
                    0: opcode = OP_LW;
                    1: opcode = OP_SW;
                    2: opcode = OP_R;
                    3: opcode = OP_BEQ;
                    4: opcode = OP_ADDI;
                    5: opcode = OP_J;
                    6: opcode = 6'($urandom);
                    default: opcode = OP_ERET;
                endcase
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_control_unit.md
IRQ_CONTROL_UNIT -- requirements
Module: irq_control_unit

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4: number of maskable interrupt channels, range 1..16.
REQ-002 SHALL have parameter VEC_BASE, default 32'h0000_0100: NMI vector address.
REQ-003 SHALL have parameter VEC_STRIDE, default 32'd16: spacing between vectors.
REQ-004 SHALL have parameter ERET_OPCODE, default 6'b010000: return-from-interrupt opcode.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 opcode  in  6  instruction-register opcode field.
REQ-009 irq  in  NUM_IRQ  level maskable requests.
REQ-010 irq_mask  in  NUM_IRQ  1 = channel masked.
REQ-011 nmint  in  1  level non-maskable request.
REQ-012 busy  in  1  1 = maskable interrupts deferred.
REQ-013 ALUOp, ALUSrcB  out  2 each; MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite  out  1 each: datapath controls.
REQ-014 PCSrc  out  3  PC source: 0 ALU, 1 ALUOut (branch), 2 jump, 3 vector_addr, 4 EPC.
REQ-015 savePC  out  1  EPC write strobe; vector_addr  out  32  registered target vector.
REQ-016 irq_ack  out  NUM_IRQ  one-hot one-cycle acknowledge; nmi_ack  out  1.
REQ-017 in_service  out  1  handler active; current_state  out  4  FSM state.

Function
REQ-018 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, IRQENTRY=12, ERET=13; codes 14-15 SHALL go to FETCH.
REQ-019 Control outputs SHALL decode combinationally from current_state; every output not listed for a state SHALL be 0.
REQ-020 FETCH: IRWrite=1, PCWrite=1, ALUSrcB=1; next DECODE, unless an interrupt is taken (REQ-030).
REQ-021 DECODE: ALUSrcB=3; next: lw/sw (100011/101011) MEMADR, R-type (000000) EXECUTE, beq (000100) BRANCH, addi (001000) ADDIEX, j (000010) JUMP, ERET_OPCODE ERET, any other FETCH.
REQ-022 MEMADR: ALUSrcA=1, ALUSrcB=2; next MEMREAD for lw, MEMWRITE for sw.
REQ-023 MEMREAD: IorD=1, next MEMWB. MEMWB: MemtoReg=1, RegWrite=1, next FETCH.
REQ-024 MEMWRITE: IorD=1, MemWrite=1, next FETCH.
REQ-025 EXECUTE: ALUSrcA=1, ALUOp=2, next ALUWB. ALUWB: RegDst=1, RegWrite=1, next FETCH.
REQ-026 BRANCH: ALUSrcA=1, ALUOp=1, PCSrc=1, Branch=1, next FETCH.
REQ-027 ADDIEX: ALUSrcA=1, ALUSrcB=2, next ADDIWB. ADDIWB: RegWrite=1, next FETCH.
REQ-028 JUMP: PCSrc=2, PCWrite=1, next FETCH.
REQ-029 Cycles per instruction SHALL be: lw 5, sw/R-type/addi 4, beq/j/ERET 3, unknown opcode 2.
REQ-030 Interrupts SHALL be sampled only in FETCH with in_service=0. take_nmi = nmint. take_irq = ~nmint & ~busy & |(irq & ~irq_mask).
REQ-031 When an interrupt is taken in FETCH: IRWrite=0, PCWrite=0, next IRQENTRY, in_service<=1, vector_addr registered.
REQ-032 vector_addr SHALL be VEC_BASE for NMI; for IRQ it SHALL be VEC_BASE+(k+1)*VEC_STRIDE, k = lowest-index unmasked pending channel; the arithmetic is 32-bit and wraps.
REQ-033 IRQENTRY: savePC=1, PCSrc=3, PCWrite=1, nmi_ack or irq_ack[k] = 1 for this cycle only, next FETCH.
REQ-034 No nesting: with in_service=1, nmint and irq SHALL be ignored until ERET completes.
REQ-035 ERET with in_service=1: PCSrc=4, PCWrite=1, in_service<=0. ERET with in_service=0: no outputs asserted. Both cases go next to FETCH.
REQ-036 An interrupt pending during the FETCH that follows ERET SHALL be taken in that FETCH.
REQ-037 Changes to irq, irq_mask or busy outside FETCH SHALL have no effect until the next FETCH.

Reset
REQ-038 With rst=1 at a clock edge, on any state including mid-instruction or IRQENTRY: current_state=FETCH, in_service=0, vector_addr=0, and all acks 0; the in-flight instruction or entry is abandoned.

Verification
REQ-039 Check lw, sw, R-type, addi, beq and j in sequence -> state traces 0-1-2-3-4, 0-1-2-5, 0-1-6-7, 0-1-9-10, 0-1-8, 0-1-11; RegWrite only in states 4, 7 and 10.
REQ-040 Check irq=4'b0110, mask=0, busy=0 in FETCH -> IRQENTRY, vector_addr=0x120, irq_ack=4'b0010 for 1 cycle, savePC=1, PCSrc=3.
REQ-041 Check nmint=1 and irq=4'b0001 with busy=1 -> vector 0x100, nmi_ack=1; then irq held until ERET, after which it is taken with vector 0x110.
REQ-042 Check busy=1 or irq_mask=4'b1111 with irq=4'b1111 -> no entry; normal fetch proceeds.
REQ-043 Check ERET with in_service=0 -> states 0-1-13-0, PCWrite=0; with in_service=1 -> PCSrc=4, PCWrite=1, in_service falls.
REQ-044 Check rst asserted in MEMREAD and in IRQENTRY -> next state FETCH, no ack, in_service=0.
